// File: rtl/pep_if_pkg.sv
// Side-channel types between the GRAM arbiter and mmacc partitions.
// Avail vector is indexed [class][bank].
package pep_if_pkg;

  import pep_mmacc_common_param_pkg::*;

  localparam int GARB_AVAIL_1H_W = SRC_NB * GARB_GRAM_NB;

  typedef logic [SRC_NB-1:0][GARB_GRAM_NB-1:0] garb_avail_1h_t;

endpackage

// File: rtl/pep_mmacc_common_param_pkg.sv
// mmacc shared constants and GRAM arbiter types.
// Class indices fix the row order of the garb avail vector.
package pep_mmacc_common_param_pkg;

  localparam int SRC_NB       = 6;
  localparam int GARB_GRAM_NB = 4;
  localparam int GARB_LEN_W   = 6;

  localparam int GARB_SRC_LDG      = 0;
  localparam int GARB_SRC_SXT      = 1;
  localparam int GARB_SRC_ACC_WR   = 2;
  localparam int GARB_SRC_ACC_RD   = 3;
  localparam int GARB_SRC_FEED_DAT = 4;
  localparam int GARB_SRC_FEED_ROT = 5;

  typedef struct packed {
    logic [GARB_GRAM_NB-1:0] gram_1h;
    logic [GARB_LEN_W-1:0]   len;
  } garb_req_t;

  typedef enum logic {
    GARB_IDLE = 1'b0,
    GARB_BUSY = 1'b1
  } garb_bank_state_e;

  // acc_wr > acc_rd > feed_rot > feed_dat > sxt > ldg
  function automatic logic [SRC_NB-1:0] garb_pick(
    input logic [SRC_NB-1:0] pool
  );
    garb_pick = '0;
    priority case (1'b1)
      pool[GARB_SRC_ACC_WR]:
        garb_pick[GARB_SRC_ACC_WR] = 1'b1;
      pool[GARB_SRC_ACC_RD]:
        garb_pick[GARB_SRC_ACC_RD] = 1'b1;
      pool[GARB_SRC_FEED_ROT]:
        garb_pick[GARB_SRC_FEED_ROT] = 1'b1;
      pool[GARB_SRC_FEED_DAT]:
        garb_pick[GARB_SRC_FEED_DAT] = 1'b1;
      pool[GARB_SRC_SXT]:
        garb_pick[GARB_SRC_SXT] = 1'b1;
      pool[GARB_SRC_LDG]:
        garb_pick[GARB_SRC_LDG] = 1'b1;
      default:
        garb_pick = '0;
    endcase
  endfunction

endpackage

// File: rtl/pep_mmacc_gram_arb_bank.sv
// Single GRAM bank slot: owner, burst counter and priority picker.
// Re-arbitrates on the last owned cycle so bursts chain without a bubble.
module pep_mmacc_gram_arb_bank
  import pep_mmacc_common_param_pkg::*;
#(
  parameter int LEN_W = GARB_LEN_W
) (
  input  logic                         clk,
  input  logic                         s_rst_n,
  input  logic [SRC_NB-1:0]            cand,
  input  logic [SRC_NB-1:0]            prom,
  input  logic [SRC_NB-1:0][LEN_W-1:0] src_len,
  output logic [SRC_NB-1:0]            win,
  output logic [SRC_NB-1:0]            owner,
  output logic                         last,
  output logic                         ovl
);

  garb_bank_state_e  state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  win_len;
  logic [SRC_NB-1:0] pool;
  logic              arb_en;

  assign last   = (state == GARB_BUSY) && (cnt == LEN_W'(1));
  assign arb_en = (state == GARB_IDLE) || last;

  assign pool = |(cand & prom) ? (cand & prom) : cand;
  assign win  = arb_en ? garb_pick(pool) : '0;

  always_comb begin
    win_len = '0;
    for (int c = 0; c < SRC_NB; c++) begin
      if (win[c]) win_len = win_len | src_len[c];
    end
  end

  assign ovl = |(owner & (owner - 1'b1));

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= GARB_IDLE;
      cnt   <= '0;
      owner <= '0;
    end else if (arb_en) begin
      if (|win) begin
        state <= GARB_BUSY;
        cnt   <= win_len;
        owner <= win;
      end else begin
        state <= GARB_IDLE;
        cnt   <= '0;
        owner <= '0;
      end
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pep_mmacc_gram_arb.sv
// GRAM bank time-slot arbiter for the six mmacc access classes.
// Starvation promotion: PEP_MMACC_GARB_STARVE_GUARD_EN.
module pep_mmacc_gram_arb
  import pep_mmacc_common_param_pkg::*;
#(
  parameter int GRAM_NB   = GARB_GRAM_NB,
  parameter int LEN_W     = GARB_LEN_W,
  parameter int STARVE_TH = 32
) (
  input  logic                      clk,
  input  logic                      s_rst_n,
  input  logic [SRC_NB-1:0]         src_req_vld,
  output logic [SRC_NB-1:0]         src_req_rdy,
  input  logic [SRC_NB*GRAM_NB-1:0] src_req_gram_1h,
  input  logic [SRC_NB*LEN_W-1:0]   src_req_len,
  output logic [SRC_NB*GRAM_NB-1:0] garb_avail_1h,
  output logic [GRAM_NB-1:0]        gram_busy,
  output logic [1:0]                error
);

  logic [SRC_NB-1:0][GRAM_NB-1:0] req_1h;
  logic [SRC_NB-1:0][GRAM_NB-1:0] avail;
  logic [SRC_NB-1:0][LEN_W-1:0]   req_len;
  logic [GRAM_NB-1:0][SRC_NB-1:0] cand;
  logic [GRAM_NB-1:0][SRC_NB-1:0] win;
  logic [GRAM_NB-1:0][SRC_NB-1:0] owner;
  logic [GRAM_NB-1:0]             last;
  logic [GRAM_NB-1:0]             ovl;
  logic [SRC_NB-1:0]              legal;
  logic [SRC_NB-1:0]              hold;
  logic [SRC_NB-1:0]              won;
  logic [SRC_NB-1:0]              prom;
  logic [SRC_NB-1:0]              acc;

  assign req_1h  = src_req_gram_1h;
  assign req_len = src_req_len;

  always_comb begin
    legal = '0;
    for (int c = 0; c < SRC_NB; c++) begin
      legal[c] = (req_1h[c] != '0)
              && ((req_1h[c] & (req_1h[c] - 1'b1)) == '0)
              && (req_len[c] != '0);
    end
  end

  // A class is held off while a burst of its own runs past this cycle.
  always_comb begin
    hold      = '0;
    avail     = '0;
    gram_busy = '0;
    for (int b = 0; b < GRAM_NB; b++) begin
      gram_busy[b] = |owner[b];
      for (int c = 0; c < SRC_NB; c++) begin
        hold[c]     = hold[c] | (owner[b][c] & ~last[b]);
        avail[c][b] = owner[b][c];
      end
    end
  end

  always_comb begin
    cand = '0;
    for (int b = 0; b < GRAM_NB; b++) begin
      for (int c = 0; c < SRC_NB; c++) begin
        cand[b][c] = src_req_vld[c] & legal[c]
                   & ~hold[c] & req_1h[c][b];
      end
    end
  end

  for (genvar b = 0; b < GRAM_NB; b++) begin : g_bank
    pep_mmacc_gram_arb_bank #(
      .LEN_W (LEN_W)
    ) u_bank (
      .clk     (clk),
      .s_rst_n (s_rst_n),
      .cand    (cand[b]),
      .prom    (prom),
      .src_len (req_len),
      .win     (win[b]),
      .owner   (owner[b]),
      .last    (last[b]),
      .ovl     (ovl[b])
    );
  end

  always_comb begin
    won = '0;
    for (int b = 0; b < GRAM_NB; b++) won = won | win[b];
  end

  // Illegal requests are swallowed on the spot; legal ones wait for a win.
  assign src_req_rdy = {SRC_NB{s_rst_n}} & src_req_vld
                     & ~hold & (~legal | won);
  assign acc           = src_req_vld & src_req_rdy;
  assign garb_avail_1h = avail;

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      error <= '0;
    end else begin
      if (|(acc & ~legal)) error[0] <= 1'b1;
      if (|ovl)            error[1] <= 1'b1;
    end
  end

`ifdef PEP_MMACC_GARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_TH) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_TH);

  logic [SRC_NB-1:0][WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wait_cnt <= '0;
    end else begin
      for (int c = 0; c < SRC_NB; c++) begin
        if (acc[c])
          wait_cnt[c] <= '0;
        else if (src_req_vld[c] && wait_cnt[c] != WAIT_MAX)
          wait_cnt[c] <= wait_cnt[c] + 1'b1;
      end
    end
  end

  always_comb begin
    prom = '0;
    for (int c = 0; c < SRC_NB; c++) begin
      prom[c] = (wait_cnt[c] >= WAIT_MAX);
    end
  end
`else
  logic starve_th_unused;
  assign starve_th_unused = STARVE_TH[0];
  assign prom             = '0;
`endif

endmodule

// File: tb/tb_pep_mmacc_gram_arb.sv
// Bench for pep_mmacc_gram_arb: directed scenarios plus random traffic
// against a cycle-level bank/owner model.
module tb_pep_mmacc_gram_arb;

  import pep_mmacc_common_param_pkg::*;
  import pep_if_pkg::*;

  localparam int GRAM_NB   = GARB_GRAM_NB;
  localparam int LEN_W     = GARB_LEN_W;
  localparam int STARVE_TH = 8;
`ifdef PEP_MMACC_GARB_STARVE_GUARD_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  localparam int PRIO [SRC_NB] = '{
    GARB_SRC_ACC_WR, GARB_SRC_ACC_RD, GARB_SRC_FEED_ROT,
    GARB_SRC_FEED_DAT, GARB_SRC_SXT, GARB_SRC_LDG
  };

  logic                           clk = 1'b0;
  logic                           s_rst_n;
  logic [SRC_NB-1:0]              src_req_vld;
  logic [SRC_NB-1:0]              src_req_rdy;
  logic [SRC_NB-1:0][GRAM_NB-1:0] req_1h;
  logic [SRC_NB-1:0][LEN_W-1:0]   req_len;
  garb_avail_1h_t                 garb_avail_1h;
  logic [GRAM_NB-1:0]             gram_busy;
  logic [1:0]                     error;

  pep_mmacc_gram_arb #(
    .GRAM_NB   (GRAM_NB),
    .LEN_W     (LEN_W),
    .STARVE_TH (STARVE_TH)
  ) dut (
    .clk             (clk),
    .s_rst_n         (s_rst_n),
    .src_req_vld     (src_req_vld),
    .src_req_rdy     (src_req_rdy),
    .src_req_gram_1h (req_1h),
    .src_req_len     (req_len),
    .garb_avail_1h   (garb_avail_1h),
    .gram_busy       (gram_busy),
    .error           (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: owner class (-1 idle) and remaining cycles per bank
  int                own   [GRAM_NB];
  int                rem   [GRAM_NB];
  int                m_win [GRAM_NB];
  int                wt    [SRC_NB];
  logic [SRC_NB-1:0] m_rdy;
  logic [1:0]        m_err;
  logic [SRC_NB-1:0] rdy_q;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic bit legal(input int c);
    return ($countones(req_1h[c]) == 1) && (req_len[c] != '0);
  endfunction

  function automatic int tgt(input int c);
    int t = -1;
    for (int b = 0; b < GRAM_NB; b++) if (req_1h[c][b]) t = b;
    return t;
  endfunction

  function automatic bit promoted(input int c);
    return STARVE_EN && (wt[c] >= STARVE_TH);
  endfunction

  function automatic garb_avail_1h_t exp_avail();
    garb_avail_1h_t a;
    a = '0;
    for (int b = 0; b < GRAM_NB; b++)
      if (own[b] >= 0) a[own[b]][b] = 1'b1;
    return a;
  endfunction

  function automatic logic [GRAM_NB-1:0] exp_busy();
    logic [GRAM_NB-1:0] v;
    v = '0;
    for (int b = 0; b < GRAM_NB; b++) v[b] = (own[b] >= 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < GRAM_NB; b++) begin
      own[b] = -1;
      rem[b] = 0;
    end
    for (int c = 0; c < SRC_NB; c++) wt[c] = 0;
    m_err = '0;
  endtask

  task automatic model_arb();
    bit outst [SRC_NB];
    m_rdy = '0;
    for (int c = 0; c < SRC_NB; c++) begin
      outst[c] = 1'b0;
      for (int b = 0; b < GRAM_NB; b++)
        if (own[b] == c && rem[b] > 1) outst[c] = 1'b1;
      if (src_req_vld[c] && !outst[c] && !legal(c)) m_rdy[c] = 1'b1;
    end
    for (int b = 0; b < GRAM_NB; b++) begin
      m_win[b] = -1;
      if (own[b] < 0 || rem[b] == 1) begin
        for (int p = 0; p < 2; p++) begin
          for (int i = 0; i < SRC_NB; i++) begin
            int k;
            k = PRIO[i];
            if (m_win[b] < 0 && src_req_vld[k] && !outst[k] && legal(k)
                && tgt(k) == b && (p == 1 || promoted(k)))
              m_win[b] = k;
          end
        end
      end
      if (m_win[b] >= 0) m_rdy[m_win[b]] = 1'b1;
    end
  endtask

  task automatic model_upd();
    for (int b = 0; b < GRAM_NB; b++) begin
      if (own[b] < 0 || rem[b] == 1) begin
        own[b] = m_win[b];
        rem[b] = 0;
        if (m_win[b] >= 0) rem[b] = int'(req_len[m_win[b]]);
      end else begin
        rem[b]--;
      end
    end
    for (int c = 0; c < SRC_NB; c++) begin
      if (m_rdy[c]) wt[c] = 0;
      else if (src_req_vld[c] && wt[c] < STARVE_TH) wt[c]++;
      if (src_req_vld[c] && m_rdy[c] && !legal(c)) m_err[0] = 1'b1;
    end
  endtask

  // one clock: inputs already driven at the preceding negedge
  task automatic step();
    #1;
    model_arb();
    rdy_q = src_req_rdy;
    check("rdy", 32'(src_req_rdy), 32'(m_rdy));
    @(posedge clk);
    model_upd();
    @(negedge clk);
    check("avail", 32'(garb_avail_1h), 32'(exp_avail()));
    check("busy", 32'(gram_busy), 32'(exp_busy()));
    check("err", 32'(error), 32'(m_err));
    for (int c = 0; c < SRC_NB; c++)
      if (m_rdy[c]) src_req_vld[c] = 1'b0;
  endtask

  task automatic set_req(input int c, input logic [GRAM_NB-1:0] bits,
                         input int len);
    req_1h[c]      = bits;
    req_len[c]     = LEN_W'(len);
    src_req_vld[c] = 1'b1;
  endtask

  task automatic reset_dut();
    s_rst_n     = 1'b0;
    src_req_vld = '0;
    model_reset();
    @(negedge clk);
    check("rst_avail", 32'(garb_avail_1h), 32'h0);
    check("rst_out", 32'({gram_busy, error, src_req_rdy}), 32'h0);
    @(negedge clk);
    s_rst_n = 1'b1;
  endtask

  task automatic new_req(input int c, input bit ill);
    logic [GRAM_NB-1:0] bits;
    int r;
    r    = $urandom_range(0, 11);
    bits = '0;
    bits[$urandom_range(0, GRAM_NB - 1)] = 1'b1;
    set_req(c, bits, $urandom_range(1, 6));
    if (ill && r == 0) req_len[c] = '0;
    if (ill && r == 1) req_1h[c] = GRAM_NB'(4'b0110);
    if (ill && r == 2) req_1h[c] = '0;
  endtask

  task automatic run_rand(input int n, input bit ill);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < SRC_NB; c++)
        if (!src_req_vld[c] && $urandom_range(0, 2) == 0) new_req(c, ill);
      step();
    end
  endtask

  initial begin
    int ldg_won;
    s_rst_n     = 1'b0;
    src_req_vld = '0;
    req_1h      = '0;
    req_len     = '0;
    rdy_q       = '0;
    reset_dut();

    // single grant: acc_rd to bank 2, len 3
    set_req(GARB_SRC_ACC_RD, 4'b0100, 3);
    step();
    check("sg_rdy", 32'(rdy_q[GARB_SRC_ACC_RD]), 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("sg_avail", 32'(garb_avail_1h[GARB_SRC_ACC_RD][2]), 32'h1);
      step();
    end
    check("sg_idle", 32'(gram_busy[2]), 32'h0);

    // contention on bank 0, acc_wr first then ldg with no bubble
    set_req(GARB_SRC_ACC_WR, 4'b0001, 4);
    set_req(GARB_SRC_LDG, 4'b0001, 4);
    step();
    check("ct_rdy", 32'(rdy_q[GARB_SRC_LDG:GARB_SRC_LDG]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("ct_accwr", 32'(garb_avail_1h[GARB_SRC_ACC_WR][0]), 32'h1);
      step();
    end
    check("ct_ldg_rdy", 32'(rdy_q[GARB_SRC_LDG]), 32'h1);
    check("ct_ldg_av", 32'(garb_avail_1h[GARB_SRC_LDG][0]), 32'h1);
    for (int i = 0; i < 4; i++) step();

    // parallel banks
    set_req(GARB_SRC_FEED_ROT, 4'b0010, 2);
    set_req(GARB_SRC_FEED_DAT, 4'b1000, 2);
    step();
    check("par_rdy", 32'(rdy_q[5:4]), 32'h3);
    for (int i = 0; i < 2; i++) begin
      check("par_rot", 32'(garb_avail_1h[GARB_SRC_FEED_ROT][1]), 32'h1);
      check("par_dat", 32'(garb_avail_1h[GARB_SRC_FEED_DAT][3]), 32'h1);
      step();
    end
    check("par_done", 32'(gram_busy), 32'h0);

    run_rand(300, 1'b0);
    for (int i = 0; i < 12; i++) step();

    // illegal request next to a legal one
    reset_dut();
    set_req(GARB_SRC_SXT, 4'b0110, 3);
    set_req(GARB_SRC_ACC_RD, 4'b0010, 2);
    step();
    check("ill_rdy", 32'(rdy_q[GARB_SRC_SXT]), 32'h1);
    check("ill_err", 32'(error[0]), 32'h1);
    check("ill_av", 32'(garb_avail_1h[GARB_SRC_SXT]), 32'h0);
    check("ill_other", 32'(garb_avail_1h[GARB_SRC_ACC_RD][1]), 32'h1);
    step();

    // asynchronous reset in the middle of a long burst
    reset_dut();
    set_req(GARB_SRC_ACC_RD, 4'b0100, 20);
    step();
    step();
    step();
    set_req(GARB_SRC_LDG, 4'b0000, 1);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("mr_avail", 32'(garb_avail_1h), 32'h0);
    check("mr_out", 32'({gram_busy, error, src_req_rdy}), 32'h0);
    src_req_vld = '0;
    model_reset();
    @(negedge clk);
    s_rst_n = 1'b1;
    set_req(GARB_SRC_ACC_RD, 4'b0100, 2);
    step();
    check("mr_regrant", 32'(garb_avail_1h[GARB_SRC_ACC_RD][2]), 32'h1);
    step();
    step();

    // acc_wr hammers bank 0 while ldg waits
    reset_dut();
    set_req(GARB_SRC_LDG, 4'b0001, 1);
    set_req(GARB_SRC_ACC_WR, 4'b0001, 1);
    ldg_won = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (rdy_q[GARB_SRC_LDG]) ldg_won++;
      if (!src_req_vld[GARB_SRC_ACC_WR])
        set_req(GARB_SRC_ACC_WR, 4'b0001, 1);
    end
    check("starve", 32'(ldg_won), 32'(STARVE_EN));
    src_req_vld = '0;
    for (int i = 0; i < 3; i++) step();

    reset_dut();
    run_rand(300, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
